// File: rtl/aload_pkg.sv
// rtl/aload_pkg.sv - shared state type and counter sizing for the async-load sequencer
package aload_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ASSERT,
    RELEASE,
    CHECK,
    DONE
  } aload_state_t;

  // One counter times both ASSERT and RELEASE, so it is sized for the longer of the two.
  function automatic int cnt_width(input int hold, input int settle);
    int longest;
    longest = (hold > settle) ? hold : settle;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/aload_cnt.sv
// rtl/aload_cnt.sv - loadable non-wrapping down-counter with a zero flag
module aload_cnt
  import aload_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aload_seq.sv
// rtl/aload_seq.sv - sequencer pulsing the async-load pins of a register bank
// Optional readback checker enabled with macro ALOAD_SEQ_CHECK_EN.
module aload_seq
  import aload_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HOLD   = 2,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  output logic             ld,
  output logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] fb_q,
  output logic             busy,
  output logic             done_valid,
  output logic             done_ok
);

  localparam int            CW        = cnt_width(HOLD, SETTLE);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  aload_state_t  state;
  aload_state_t  state_nx;
  logic          accept;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic [CW-1:0] cnt_val;

  aload_cnt #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .arst     (arst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ASSERT;
      ASSERT:  if (cnt_zero) state_nx = RELEASE;
`ifdef ALOAD_SEQ_CHECK_EN
      RELEASE: if (cnt_zero) state_nx = CHECK;
`else
      RELEASE: if (cnt_zero) state_nx = DONE;
`endif
      CHECK:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The counter is reloaded on the last ASSERT cycle so RELEASE starts with SETTLE-1.
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    done_valid = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = HOLD_LD;
    case (state)
      IDLE: begin
        req_ready = !arst;
        busy      = 1'b0;
      end
      SETUP: cnt_load = 1'b1;
      ASSERT: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RELEASE: cnt_dec = 1'b1;
      DONE:    done_valid = 1'b1;
      default: ;
    endcase
  end

  // ld comes straight from a flop so no decode glitch can reach the async pin.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ld     <= 1'b0;
      ld_val <= '0;
    end else begin
      ld <= (state_nx == ASSERT);
      if (accept) begin
        ld_val <= req_value;
      end
    end
  end

`ifdef ALOAD_SEQ_CHECK_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      done_ok <= 1'b0;
    end else if (state == CHECK) begin
      done_ok <= (fb_q == ld_val);
    end
  end
`else
  logic unused_fb;

  assign done_ok   = 1'b1;
  assign unused_fb = ^fb_q;
`endif

endmodule

// File: doc/aload_seq.md
# aload_seq

Sequencer that drives the asynchronous-load pins of a bank of async-load flip-flops: it takes a load value over a valid/ready handshake, presents it on the bank's load-value inputs, and pulses the bank's async-load input glitch-free for a fixed hold time. It then releases the load with a settle margin, optionally reads the bank's outputs back to confirm the load took, and reports completion. It sits between control logic and any `WIDTH`-wide register bank built from async-load cells. Its `ld`/`ld_val` outputs connect to the cells' `arst`/`rval` pins, and `fb_q` connects to their `q`.

## Interface
Parameters:
- `WIDTH`, default 8: bank width in bits.
- `HOLD`, default 2: number of cycles `ld` stays high. Must be at least 1.
- `SETTLE`, default 2: number of cycles `ld_val` is held after `ld` falls. Must be at least 1.

Ports:
- `clk`  in  1: the single clock; all state updates on its posedge.
- `arst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  1: load request.
- `req_ready`  out  1: high only in IDLE.
- `req_value`  in  `WIDTH`: value to load; sampled on acceptance.
- `ld`  out  `WIDTH`-independent, 1 bit: async-load strobe to the bank. Driven directly from a flop.
- `ld_val`  out  `WIDTH`: load value to the bank. Registered.
- `fb_q`  in  `WIDTH`: bank outputs, used for readback.
- `busy`  out  1: high whenever the state is not IDLE.
- `done_valid`  out  1: one-cycle completion pulse.
- `done_ok`  out  1: readback matched; valid only while `done_valid` is high.

## Operation
- States:
  - IDLE → SETUP on `req_valid && req_ready`; `req_value` is latched into `ld_val`.
  - SETUP: one cycle. `ld=0` and `ld_val` is stable. This guarantees data setup before the async pin rises.
  - ASSERT: `HOLD` cycles with `ld=1`.
  - RELEASE: `SETTLE` cycles with `ld=0` and `ld_val` unchanged. This guarantees data hold across the async deassertion.
  - CHECK: one cycle. Registers `done_ok <= (fb_q == ld_val)`.
  - DONE: one cycle with `done_valid=1`, then return to IDLE.
- `ld_val` changes only on the IDLE→SETUP transition.
- `ld` is a flop output with no combinational path, so no glitches reach the async pin.
- A single down-counter serves both ASSERT and RELEASE:
  - Loaded with `HOLD-1` on entry to ASSERT and with `SETTLE-1` on entry to RELEASE.
  - Each state exits when the counter reaches 0.
  - Counter width is `$clog2(max(HOLD,SETTLE)+1)`. It does not wrap.
- A request arriving during any non-IDLE state, DONE included, is not accepted; `req_ready=0`. There is no queuing.
- A new request can be accepted in the cycle after DONE.
- Reset (`arst` high), at any point including mid-ASSERT:
  - Immediately, without waiting for a clock edge: state=IDLE, `ld=0`, `ld_val=0`, `done_valid=0`, `done_ok=0`, counter=0.
  - `busy=0` and `req_ready=1` once `arst` is low.
  - The bank keeps whatever value it has; no completion is reported for the aborted request.

## Timing
- Let the acceptance edge be E0. Edge E1 is then the first `clk` edge after E0, and each later En follows in turn.
- `ld` is high from edge E1 up to E(1+HOLD).
- RELEASE occupies E(1+HOLD) up to E(1+HOLD+SETTLE).
- CHECK occupies the next cycle.
- `done_valid` is high for exactly the cycle following E(2+HOLD+SETTLE).
- Total request-to-done latency is `HOLD+SETTLE+3` edges; the next request can be accepted at E(HOLD+SETTLE+3).
- With the checker compiled out, the latency is `HOLD+SETTLE+2` edges.
- `fb_q` is sampled at least `SETTLE+1` edges after `ld` falls.

## Configuration
- Macro `ALOAD_SEQ_CHECK_EN`.
- Defined: CHECK state present and `done_ok` computed from readback as above.
- Undefined:
  - CHECK state is removed and RELEASE goes straight to DONE.
  - `done_ok` is tied to 1.
  - `fb_q` is unused.

## Structure
- Shared package `aload_pkg`:
  - State enum `aload_state_t` with IDLE, SETUP, ASSERT, RELEASE, CHECK, DONE.
  - Counter-width helper function.
- One natural sub-module, `aload_cnt`: a loadable down-counter with a `zero` flag, shared by ASSERT and RELEASE.
- Everything else lives in a single FSM process plus output flops.

## Test plan
- `WIDTH=8`, `HOLD=2`, `SETTLE=2`; request `0xA5` with the bank model connected → `ld` high for exactly 2 cycles from E1, `ld_val=0xA5` from E1 through DONE, `done_valid` for one cycle after E6, `done_ok=1`.
- Same setup, but force `fb_q=0xA4` during CHECK → `done_ok=0` on the `done_valid` pulse.
- Hold `req_valid` high continuously with `0x01` then `0x02` → exactly one acceptance per 7-edge transaction, `req_ready=0` throughout, no overlap of `ld` pulses.
- Assert `arst` mid-ASSERT → `ld` and `ld_val` drop to 0 without a clock edge, `done_valid` never pulses, and a request after `arst` is released is accepted normally.
- `HOLD=1`, `SETTLE=1` → `ld` is high for exactly one cycle and `done_valid` pulses after E4.
- Build without `ALOAD_SEQ_CHECK_EN` and drive `fb_q` with garbage → `done_valid` pulses after E5 with `done_ok=1`.
